// File: rtl/fir_pkg.sv
// Shared defaults and serializer state encoding for the FIR output serializer.
package fir_pkg;

  localparam int M_DEFAULT     = 24;
  localparam int W_DEFAULT     = 16;
  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SHIFT = 2'd2
  } ser_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small circular FIFO holding converted words between the FIR strobe and the serializer.
module sample_fifo
  import fir_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level,
  output logic          full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO still succeeds when the head leaves on the same edge.
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && (level != '0);
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Pointers wrap at DEPTH; occupancy moves only when exactly one side is active.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers and level.
  always_ff @(posedge ck) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fir_out_serial.sv
// Rounds and saturates FIR samples to W bits, buffers them, and sends each as a sync-framed MSB-first serial word.
module fir_out_serial
  import fir_pkg::*;
#(
  parameter int M     = M_DEFAULT,
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                         ck,
  input  logic                         rst,
  input  logic signed [M-1:0]          in,
  input  logic                         input_ready,
  output logic                         sdata,
  output logic                         sync,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);

  localparam int SH = M - W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic signed [M:0] ROUND   = (M+1)'(1) <<< (SH - 1);
  localparam logic signed [M:0] SAT_MAX = (M+1)'((1 <<< (W - 1)) - 1);
  localparam logic signed [M:0] SAT_MIN = ~SAT_MAX;

  logic signed [M:0] rounded;
  logic signed [M:0] shifted;
  logic [W-1:0]      word;
  logic [W-1:0]      rdata;
  logic              full;
  logic              pop;

  ser_state_t   state;
  ser_state_t   state_next;
  logic [W-1:0] shreg;
  logic [CW-1:0] bit_cnt;
  logic         sync_next;
  logic         sdata_next;
  logic         load;
  logic         shift_en;
  logic         cnt_clear;

  // Round half up, drop the low bits, then clamp into the W-bit signed range.
  always_comb begin
    rounded = $signed({in[M-1], in}) + ROUND;
    shifted = rounded >>> SH;
    if (shifted > SAT_MAX)      word = SAT_MAX[W-1:0];
    else if (shifted < SAT_MIN) word = SAT_MIN[W-1:0];
    else                        word = shifted[W-1:0];
  end

  sample_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ck    (ck),
    .rst   (rst),
    .push  (input_ready),
    .pop   (pop),
    .wdata (word),
    .rdata (rdata),
    .level (level),
    .full  (full)
  );

  // Serializer state register.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state plus the values the registered sync/sdata pins take on the coming edge.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    cnt_clear  = 1'b0;
    sync_next  = 1'b0;
    sdata_next = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop        = 1'b1;
          load       = 1'b1;
          sync_next  = 1'b1;
          state_next = SYNC;
        end
      end
      SYNC: begin
        sdata_next = shreg[W-1];
        shift_en   = 1'b1;
        cnt_clear  = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (bit_cnt == CW'(W - 1)) begin
          state_next = IDLE;
        end else begin
          sdata_next = shreg[W-1];
          shift_en   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift register, bit counter and glitch-free registered serial pins.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      sdata   <= 1'b0;
      sync    <= 1'b0;
    end else begin
      sdata <= sdata_next;
      sync  <= sync_next;
      if (load)          shreg <= rdata;
      else if (shift_en) shreg <= shreg << 1;
      if (cnt_clear)     bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + CW'(1);
    end
  end

  // Sticky drop flag: a strobe arrived while full and nothing left the FIFO.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst)                              overflow <= 1'b0;
    else if (input_ready && full && !pop)  overflow <= 1'b1;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fir_out_serial.sv
// Scoreboard bench: stimulus queues expected words, a monitor deserializes frames and compares.
module tb_fir_out_serial;

  localparam int M     = 24;
  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic                 ck = 1'b0;
  logic                 rst = 1'b0;
  logic signed [M-1:0]  in_s = '0;
  logic                 input_ready = 1'b0;
  logic                 sdata;
  logic                 sync;
  logic                 busy;
  logic [LW-1:0]        level;
  logic                 overflow;

  int           checks = 0;
  int           errors = 0;
  int           frames = 0;
  logic [W-1:0] exp_q[$];

  always #5 ck = ~ck;

  fir_out_serial #(
    .M     (M),
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .ck          (ck),
    .rst         (rst),
    .in          (in_s),
    .input_ready (input_ready),
    .sdata       (sdata),
    .sync        (sync),
    .busy        (busy),
    .level       (level),
    .overflow    (overflow)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [M-1:0] value, input logic [W-1:0] expected, input bit accepted);
    @(negedge ck);
    in_s        = value;
    input_ready = 1'b1;
    if (accepted) exp_q.push_back(expected);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge ck);
      n++;
    end
    check_output({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check_output({name, "_busy"}, 32'(busy), 32'd0);
    repeat (2) @(negedge ck);
  endtask

  // Monitor: on each sync, collect the next W sdata bits and compare with the queue head.
  initial begin : monitor
    logic [W-1:0] shift_word;
    int           bit_count;
    bit           active;
    active     = 1'b0;
    bit_count  = 0;
    shift_word = '0;
    forever begin
      @(negedge ck);
      if (!rst) begin
        active = 1'b0;
      end else if (active) begin
        shift_word = {shift_word[W-2:0], sdata};
        bit_count++;
        if (bit_count == 1) check_output("sync_one_cycle", 32'(sync), 32'd0);
        if (bit_count == W) begin
          active = 1'b0;
          frames++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_unexpected: got 0x%0h, want no frame", shift_word);
          end else begin
            check_output("frame_word", 32'(shift_word), 32'(exp_q.pop_front()));
          end
        end
      end else if (sync) begin
        active     = 1'b1;
        bit_count  = 0;
        shift_word = '0;
        check_output("sync_sdata_low", 32'(sdata), 32'd0);
      end
    end
  end

  // Hard stop if something hangs.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [M-1:0] vin  [6];
    logic [W-1:0] vexp [6];
    int           frames_before;
    int           activity;
    int           max_level;
    int           w;

    vin  = '{24'hFFD8F0, 24'h7FFFFF, 24'h800000, 24'h00007F, 24'h000080, 24'hFFFF7F};
    vexp = '{16'hFFD9,   16'h7FFF,   16'h8000,   16'h0000,   16'h0001,   16'hFFFF};

    // Reset state
    repeat (3) @(negedge ck);
    check_output("rst_sdata", 32'(sdata), 32'd0);
    check_output("rst_sync", 32'(sync), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_level", 32'(level), 32'd0);
    check_output("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge ck);

    // First sample 10000 -> 0x0027, with latency checks
    apply_stimulus(24'd10000, 16'h0027, 1'b1);
    @(negedge ck);
    input_ready = 1'b0;
    check_output("lat_level_after_push", 32'(level), 32'd1);
    check_output("lat_busy_idle", 32'(busy), 32'd0);
    check_output("lat_sync_early", 32'(sync), 32'd0);
    @(negedge ck);
    check_output("lat_sync_high", 32'(sync), 32'd1);
    check_output("lat_busy_high", 32'(busy), 32'd1);
    check_output("lat_level_popped", 32'(level), 32'd0);
    wait_drain("drain_10000");

    // Conversion vectors: sign, saturation and rounding boundaries
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vin[i], vexp[i], 1'b1);
      @(negedge ck);
      input_ready = 1'b0;
      wait_drain("drain_vec");
    end

    // Six back-to-back strobes from empty/IDLE: five kept, sixth dropped
    check_output("ovf_clear_before", 32'(overflow), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      apply_stimulus(24'(i * 256), 16'(i), i <= 5);
    end
    @(negedge ck);
    input_ready = 1'b0;
    check_output("ovf_level_full", 32'(level), 32'd4);
    check_output("ovf_flag_set", 32'(overflow), 32'd1);
    wait_drain("drain_ovf");
    check_output("ovf_sticky", 32'(overflow), 32'd1);
    check_output("ovf_level_empty", 32'(level), 32'd0);

    // Reset at bit 7 of a frame, with a second word still queued
    apply_stimulus(24'h7FFFFF, 16'h7FFF, 1'b1);
    apply_stimulus(24'h555500, 16'h5555, 1'b1);
    @(negedge ck);
    input_ready = 1'b0;
    repeat (9) @(negedge ck);
    check_output("mid_bit7_before_reset", 32'(sdata), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_output("mid_rst_sdata", 32'(sdata), 32'd0);
    check_output("mid_rst_sync", 32'(sync), 32'd0);
    check_output("mid_rst_level", 32'(level), 32'd0);
    check_output("mid_rst_busy", 32'(busy), 32'd0);
    check_output("mid_rst_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge ck);
    rst = 1'b1;
    frames_before = frames;
    activity = 0;
    repeat (40) begin
      @(negedge ck);
      if (sdata || sync || busy) activity++;
    end
    check_output("mid_no_activity", 32'(activity), 32'd0);
    check_output("mid_no_frames", 32'(frames - frames_before), 32'd0);

    // Strobe on the very first edge after reset release is accepted
    @(negedge ck);
    rst = 1'b0;
    @(negedge ck);
    rst         = 1'b1;
    in_s        = 24'h000080;
    input_ready = 1'b1;
    exp_q.push_back(16'h0001);
    @(negedge ck);
    input_ready = 1'b0;
    check_output("first_edge_level", 32'(level), 32'd1);
    wait_drain("drain_first_edge");

    // One strobe every 25 cycles for 10 frames
    frames_before = frames;
    max_level = 0;
    for (int n = 0; n < 10; n++) begin
      w = n * 1111 - 5000;
      apply_stimulus(24'(w * 256), 16'(w), 1'b1);
      repeat (24) begin
        @(negedge ck);
        input_ready = 1'b0;
        if (int'(level) > max_level) max_level = int'(level);
      end
    end
    wait_drain("drain_rate");
    check_output("rate_frames", 32'(frames - frames_before), 32'd10);
    check_output("rate_max_level", 32'(max_level), 32'd1);
    check_output("rate_overflow", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
